stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop and lap/reset button controller for a mm:ss stopwatch.
// Each raw button passes through a 2-flop synchronizer, then a saturating debouncer.
// A rising debounced level gives a one-cycle press event, which drives a 4-state FSM.
// Optional build macro STOPWATCH_AUTO_STOP_EN: the stopwatch pauses automatically at 59:59.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       lap_load,
  output logic [1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] raw_btn;
  logic [1:0] press;     // bit 0: start/stop, bit 1: lap/reset

  assign raw_btn = {btn_lr, btn_ss};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [1:0]    sync;
    logic          lvl;
    logic          lvl_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
      if (reset) sync <= '0;
      else       sync <= {sync[0], raw_btn[g]};
    end

    // Debounce: accept the synchronized level after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
      end else begin
        lvl_d <= lvl;
        if (sync[1] == lvl) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl <= sync[1];
          cnt <= '0;
        end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = lvl & ~lvl_d;
  end

  // Next-state decode; start/stop wins over lap/reset when both fire together
  always_comb begin
    state_d = state_q;
    if (press[0]) begin
      case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        LAP:     state_d = PAUSED;
        default: state_d = state_q;
      endcase
    end else if (press[1]) begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUNNING: state_d = LAP;
        PAUSED:  state_d = IDLE;
        LAP:     state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end
`ifdef STOPWATCH_AUTO_STOP_EN
    if ((state_q == RUNNING || state_q == LAP) && minutes == 6'd59 && seconds == 6'd59)
      state_d = PAUSED;
`endif
  end

`ifndef STOPWATCH_AUTO_STOP_EN
  logic unused_time;
  assign unused_time = ^{seconds, minutes};
`endif

  // State register plus one-cycle transition pulses aligned with the new state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_clr  <= 1'b0;
      lap_load <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_clr  <= (state_q == PAUSED) && (state_d == IDLE);
      lap_load <= (state_q == RUNNING) && (state_d == LAP);
    end
  end

  assign cnt_en   = (state_q == RUNNING) || (state_q == LAP);
  assign lap_hold = (state_q == LAP);
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and randomized stimulus against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_ss;
  logic       btn_lr;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic       lap_load;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .seconds  (seconds),
    .minutes  (minutes),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_hold (lap_hold),
    .lap_load (lap_load),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw history delay line, mismatch run lengths, transition tables
  // States: 0 idle, 1 running, 2 paused, 3 lap
  int         ss_tab[4] = '{1, 2, 1, 2};
  int         lr_tab[4] = '{0, 3, 0, 1};
  logic [1:0] hist[$] = '{2'b00, 2'b00};
  logic [1:0] m_deb = '0;
  logic [1:0] m_deb_d = '0;
  int         run[2] = '{0, 0};
  int         m_st = 0;
  bit         m_clr = 0;
  bit         m_load = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input logic [1:0] raw, input int sec, input int mins);
    logic [1:0] s2;
    logic [1:0] pr;
    int         nxt;
    if (rst) begin
      hist = '{2'b00, 2'b00};
      m_deb = '0; m_deb_d = '0; run = '{0, 0};
      m_st = 0; m_clr = 0; m_load = 0;
      return;
    end
    s2  = hist[0];
    pr  = m_deb & ~m_deb_d;
    nxt = m_st;
    if (pr[0])      nxt = ss_tab[m_st];
    else if (pr[1]) nxt = lr_tab[m_st];
`ifdef STOPWATCH_AUTO_STOP_EN
    if ((m_st == 1 || m_st == 3) && sec == 59 && mins == 59) nxt = 2;
`endif
    m_clr  = (m_st == 2 && nxt == 0);
    m_load = (m_st == 1 && nxt == 3);
    m_st   = nxt;
    m_deb_d = m_deb;
    for (int b = 0; b < 2; b++) begin
      if (s2[b] != m_deb[b]) begin
        run[b]++;
        if (run[b] == D) begin
          m_deb[b] = s2[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    void'(hist.pop_front());
    hist.push_back(raw);
  endtask

  // One clock: drive inputs, advance model, compare all outputs on the falling edge
  task automatic step(input bit rst, input bit ss, input bit lr);
    reset  = rst;
    btn_ss = ss;
    btn_lr = lr;
    model_edge(rst, {lr, ss}, int'(seconds), int'(minutes));
    @(posedge clk);
    @(negedge clk);
    check("state",    int'(state),    m_st);
    check("cnt_en",   int'(cnt_en),   int'(m_st == 1 || m_st == 3));
    check("lap_hold", int'(lap_hold), int'(m_st == 3));
    check("cnt_clr",  int'(cnt_clr),  int'(m_clr));
    check("lap_load", int'(lap_load), int'(m_load));
  endtask

  task automatic hold(input bit ss, input bit lr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, ss, lr);
  endtask

  task automatic press_btn(input bit ss, input bit lr);
    hold(ss, lr, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  int clr_pulses;
  int load_pulses;
  bit r_ss;
  bit r_lr;
  bit r_rst;

  initial begin
    reset = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; seconds = '0; minutes = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("reset_state", int'(state), 0);
    check("reset_outs",  int'({cnt_en, cnt_clr, lap_hold, lap_load}), 0);

    // Long hold of start/stop gives exactly one press
    hold(1'b1, 1'b0, 20);
    check("hold_state", int'(state), 1);
    check("hold_en",    int'(cnt_en), 1);
    hold(1'b0, 1'b0, 10);
    check("release_state", int'(state), 1);

    // Bouncing shorter than the debounce window is ignored
    for (int i = 0; i < 30; i++) step(1'b0, (i % 4) < 2, 1'b0);
    hold(1'b0, 1'b0, 10);
    check("bounce_state", int'(state), 1);

    // lr, lr, ss, lr sequence with pulse counting on the lap and clear strobes
    clr_pulses = 0; load_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20; i++) begin
        step(1'b0, (k == 2) && i < 10, (k != 2) && i < 10);
        clr_pulses  += int'(cnt_clr);
        load_pulses += int'(lap_load);
      end
      if (k == 0) check("lap_state", int'(state), 3);
      if (k == 1) check("back_run_state", int'(state), 1);
      if (k == 2) check("pause_state", int'(state), 2);
    end
    check("seq_idle", int'(state), 0);
    check("load_pulses", load_pulses, 1);
    check("clr_pulses", clr_pulses, 1);

    // Simultaneous presses in RUNNING: start/stop wins
    press_btn(1'b1, 1'b0);
    load_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i < 12, i < 12);
      load_pulses += int'(lap_load);
    end
    check("simul_state", int'(state), 2);
    check("simul_noload", load_pulses, 0);

    // Reset in LAP while lap/reset is mid-debounce
    press_btn(1'b1, 1'b0);
    press_btn(1'b0, 1'b1);
    check("pre_rst_lap", int'(state), 3);
    hold(1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 1'b1);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_outs", int'({cnt_en, cnt_clr, lap_hold, lap_load}), 0);
    hold(1'b0, 1'b0, 15);
    check("post_rst_state", int'(state), 0);

    // 59:59 while running
    press_btn(1'b1, 1'b0);
    seconds = 6'd59; minutes = 6'd59;
    hold(1'b0, 1'b0, 5);
`ifdef STOPWATCH_AUTO_STOP_EN
    check("autostop_state", int'(state), 2);
    check("autostop_en", int'(cnt_en), 0);
`else
    check("wrap_state", int'(state), 1);
`endif
    seconds = '0; minutes = '0;

    // Randomized buttons, occasional reset and time values
    step(1'b1, 1'b0, 1'b0);
    r_ss = 0; r_lr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) r_ss = ~r_ss;
      if ($urandom_range(5) == 0) r_lr = ~r_lr;
      r_rst = ($urandom_range(299) == 0);
      if ($urandom_range(19) == 0) begin
        seconds = 6'd59; minutes = 6'd59;
      end else begin
        seconds = 6'($urandom_range(59)); minutes = 6'($urandom_range(59));
      end
      step(r_rst, r_ss, r_lr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
